color_match_judge: RTL and testbench

COLOR_MATCH_JUDGE -- requirements
Module: color_match_judge

---
 rtl/color_pkg.sv | 22 ++
 rtl/color_match_judge_if.sv | 34 +++
 rtl/color_match_unit.sv | 23 ++
 rtl/color_match_judge.sv | 118 +++++++++++
 tb/tb_color_match_judge.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/color_pkg.sv
// Shared types and helpers for the color match judge: FSM states, color geometry and
// platform field selection.
package color_pkg;

  localparam int unsigned COLOR_W   = 3;
  localparam int unsigned NUM_PLATS = 4;
  localparam int unsigned PLATS_W   = COLOR_W * NUM_PLATS;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StArmed,
    StOver
  } state_e;

  // Platform k occupies bits [3k+2:3k].
  function automatic logic [COLOR_W-1:0] plat_sel(input logic [PLATS_W-1:0] plats,
                                                  input logic [1:0]         idx);
    return plats[32'(idx) * COLOR_W +: COLOR_W];
  endfunction

endpackage

// File: rtl/color_match_judge_if.sv
// Game-side bundle of the color match judge: generator handshake, landing strobe, and
// round/score status.
interface color_match_judge_if
  import color_pkg::*;
#(
  parameter int unsigned SCORE_W = 8
);

  logic                 start;
  logic                 colors_req;
  logic                 colors_valid;
  logic [PLATS_W-1:0]   new_color_plats;
  logic [COLOR_W-1:0]   new_color_ball;
  logic                 land_valid;
  logic [1:0]           land_pos;
  logic [PLATS_W-1:0]   plat_colors;
  logic [COLOR_W-1:0]   ball_color;
  logic [SCORE_W-1:0]   score;
  logic [1:0]           lives;
  logic                 hit;
  logic                 miss;
  logic                 game_over;

  modport master (
    output start, colors_valid, new_color_plats, new_color_ball, land_valid, land_pos,
    input  colors_req, plat_colors, ball_color, score, lives, hit, miss, game_over
  );

  modport slave (
    input  start, colors_valid, new_color_plats, new_color_ball, land_valid, land_pos,
    output colors_req, plat_colors, ball_color, score, lives, hit, miss, game_over
  );

endinterface

// File: rtl/color_match_unit.sv
// Combinational color comparator: match of the ball against the selected platform, and
// whether the ball color appears on any platform at all.
module color_match_unit
  import color_pkg::*;
(
  input  logic [PLATS_W-1:0] plats,
  input  logic [COLOR_W-1:0] ball,
  input  logic [1:0]         pos,
  output logic               match,
  output logic               ball_in_set
);

  always_comb begin
    match       = (plat_sel(plats, pos) == ball);
    ball_in_set = 1'b0;
    for (int k = 0; k < NUM_PLATS; k++) begin
      if (plat_sel(plats, 2'(k)) == ball) begin
        ball_in_set = 1'b1;
      end
    end
  end

endmodule

// File: rtl/color_match_judge.sv
// Color match judge: fetches a color set per round, scores landings against the ball
// color and tracks lives until the game is over.
module color_match_judge
  import color_pkg::*;
#(
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned SCORE_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  color_match_judge_if.slave bus
);

  state_e               state_q, state_d;
  logic [PLATS_W-1:0]   plats_q, plats_d;
  logic [COLOR_W-1:0]   ball_q, ball_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [1:0]           lives_q, lives_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic                 req_q, req_d;
  logic                 over_q, over_d;

  logic [PLATS_W-1:0]   unit_plats;
  logic [COLOR_W-1:0]   unit_ball;
  logic                 unit_match;
  logic                 unit_in_set;

  // In FETCH the unit screens the incoming set; otherwise it judges the latched round.
  assign unit_plats = (state_q == StFetch) ? bus.new_color_plats : plats_q;
  assign unit_ball  = (state_q == StFetch) ? bus.new_color_ball  : ball_q;

  color_match_unit u_match (
    .plats       (unit_plats),
    .ball        (unit_ball),
    .pos         (bus.land_pos),
    .match       (unit_match),
    .ball_in_set (unit_in_set)
  );

  always_comb begin
    state_d = state_q;
    plats_d = plats_q;
    ball_d  = ball_q;
    score_d = score_q;
    lives_d = lives_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;

    unique case (state_q)
      StIdle, StOver: begin
        if (bus.start) begin
          state_d = StFetch;
          score_d = '0;
          lives_d = 2'(START_LIVES);
        end
      end
      StFetch: begin
        if (bus.colors_valid && unit_in_set) begin
          plats_d = bus.new_color_plats;
          ball_d  = bus.new_color_ball;
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (bus.land_valid) begin
          if (unit_match) begin
            hit_d   = 1'b1;
            score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
            state_d = StFetch;
          end else begin
            miss_d  = 1'b1;
            lives_d = lives_q - 2'd1;
            state_d = (lives_q == 2'd1) ? StOver : StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    req_d  = (state_d == StFetch);
    over_d = (state_d == StOver);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      plats_q <= '0;
      ball_q  <= '0;
      score_q <= '0;
      lives_q <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      req_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      plats_q <= plats_d;
      ball_q  <= ball_d;
      score_q <= score_d;
      lives_q <= lives_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      req_q   <= req_d;
      over_q  <= over_d;
    end
  end

  assign bus.colors_req  = req_q;
  assign bus.plat_colors = plats_q;
  assign bus.ball_color  = ball_q;
  assign bus.score       = score_q;
  assign bus.lives       = lives_q;
  assign bus.hit         = hit_q;
  assign bus.miss        = miss_q;
  assign bus.game_over   = over_q;

endmodule

// File: tb/tb_color_match_judge.sv
// Bench for color_match_judge: directed scenarios plus a randomized run against a
// round-level behavioural model.
module tb_color_match_judge;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  color_match_judge_if #(.SCORE_W(8)) bus ();

  color_match_judge #(
    .START_LIVES (3),
    .SCORE_W     (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: game phase as text, colors and counters as plain integers.
  string       m_phase;
  logic [11:0] m_plats;
  int          m_ball;
  int          m_score;
  int          m_lives;
  bit          m_hit;
  bit          m_miss;

  task automatic idle_inputs();
    bus.start           = 1'b0;
    bus.colors_valid    = 1'b0;
    bus.new_color_plats = '0;
    bus.new_color_ball  = '0;
    bus.land_valid      = 1'b0;
    bus.land_pos        = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_set(input logic [11:0] plats, input logic [2:0] ball);
    bus.colors_valid    = 1'b1;
    bus.new_color_plats = plats;
    bus.new_color_ball  = ball;
    tick();
    bus.colors_valid    = 1'b0;
  endtask

  task automatic land(input logic [1:0] pos);
    bus.land_valid = 1'b1;
    bus.land_pos   = pos;
    tick();
    bus.land_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #13;
    checks++;
    if ({bus.colors_req, bus.plat_colors, bus.ball_color, bus.score, bus.lives, bus.hit,
         bus.miss, bus.game_over} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b plats=%o ball=%0d score=%0d lives=%0d hit=%b miss=%b over=%b, want all 0",
               bus.colors_req, bus.plat_colors, bus.ball_color, bus.score, bus.lives,
               bus.hit, bus.miss, bus.game_over);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (bus.colors_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req: got %b want 0", bus.colors_req);
    end
  endtask

  task automatic test_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if ({bus.colors_req, bus.score, bus.lives, bus.game_over} !== {1'b1, 8'd0, 2'd3, 1'b0}) begin
      failures++;
      $display("FAIL start: got req=%b score=%0d lives=%0d over=%b want 1 0 3 0",
               bus.colors_req, bus.score, bus.lives, bus.game_over);
    end
    tick();
    checks++;
    if (bus.colors_req !== 1'b1) begin
      failures++;
      $display("FAIL fetch_hold_req: got %b want 1", bus.colors_req);
    end
  endtask

  task automatic test_fetch_hit();
    load_set(12'o7531, 3'd5);
    checks++;
    if ({bus.plat_colors, bus.ball_color, bus.colors_req} !== {12'o7531, 3'd5, 1'b0}) begin
      failures++;
      $display("FAIL latch_set: got plats=%o ball=%0d req=%b want 7531 5 0",
               bus.plat_colors, bus.ball_color, bus.colors_req);
    end
    land(2'd2);
    checks++;
    if ({bus.hit, bus.miss, bus.score, bus.colors_req} !== {1'b1, 1'b0, 8'd1, 1'b1}) begin
      failures++;
      $display("FAIL hit: got hit=%b miss=%b score=%0d req=%b want 1 0 1 1",
               bus.hit, bus.miss, bus.score, bus.colors_req);
    end
    tick();
    checks++;
    if (bus.hit !== 1'b0) begin
      failures++;
      $display("FAIL hit_one_cycle: got %b want 0", bus.hit);
    end
  endtask

  task automatic test_miss_to_over();
    for (int i = 0; i < 3; i++) begin
      load_set(12'o7531, 3'd5);
      land(2'd0);
      checks++;
      if ({bus.miss, bus.hit, bus.lives, bus.game_over, bus.colors_req} !==
          {1'b1, 1'b0, 2'(2 - i), (i == 2), (i != 2)}) begin
        failures++;
        $display("FAIL miss_%0d: got miss=%b hit=%b lives=%0d over=%b req=%b want lives=%0d",
                 i, bus.miss, bus.hit, bus.lives, bus.game_over, bus.colors_req, 2 - i);
      end
    end
    load_set(12'o2222, 3'd2);
    tick();
    checks++;
    if ({bus.game_over, bus.miss, bus.plat_colors, bus.score, bus.lives} !==
        {1'b1, 1'b0, 12'o7531, 8'd1, 2'd0}) begin
      failures++;
      $display("FAIL over_hold: got over=%b miss=%b plats=%o score=%0d lives=%0d",
               bus.game_over, bus.miss, bus.plat_colors, bus.score, bus.lives);
    end
  endtask

  task automatic test_reject();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if ({bus.game_over, bus.score, bus.lives, bus.colors_req} !== {1'b0, 8'd0, 2'd3, 1'b1}) begin
      failures++;
      $display("FAIL restart: got over=%b score=%0d lives=%0d req=%b",
               bus.game_over, bus.score, bus.lives, bus.colors_req);
    end
    load_set(12'o1111, 3'd6);
    checks++;
    if ({bus.colors_req, bus.plat_colors, bus.ball_color} !== {1'b1, 12'o7531, 3'd5}) begin
      failures++;
      $display("FAIL reject_set: got req=%b plats=%o ball=%0d want 1 7531 5",
               bus.colors_req, bus.plat_colors, bus.ball_color);
    end
  endtask

  task automatic test_ignored();
    land(2'd1);
    checks++;
    if ({bus.hit, bus.miss, bus.colors_req, bus.score, bus.lives} !==
        {1'b0, 1'b0, 1'b1, 8'd0, 2'd3}) begin
      failures++;
      $display("FAIL land_in_fetch: got hit=%b miss=%b req=%b score=%0d lives=%0d",
               bus.hit, bus.miss, bus.colors_req, bus.score, bus.lives);
    end
    load_set(12'o7531, 3'd5);
    bus.start = 1'b1;
    load_set(12'o6420, 3'd4);
    bus.start = 1'b0;
    checks++;
    if ({bus.plat_colors, bus.ball_color, bus.colors_req, bus.score, bus.lives} !==
        {12'o7531, 3'd5, 1'b0, 8'd0, 2'd3}) begin
      failures++;
      $display("FAIL valid_in_armed: got plats=%o ball=%0d req=%b score=%0d lives=%0d",
               bus.plat_colors, bus.ball_color, bus.colors_req, bus.score, bus.lives);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 256; i++) begin
      land(2'd2);
      load_set(12'o7531, 3'd5);
    end
    checks++;
    if (bus.score !== 8'd255) begin
      failures++;
      $display("FAIL score_reach_max: got %0d want 255", bus.score);
    end
    land(2'd2);
    checks++;
    if ({bus.hit, bus.score} !== {1'b1, 8'd255}) begin
      failures++;
      $display("FAIL score_saturate: got hit=%b score=%0d want 1 255", bus.hit, bus.score);
    end
  endtask

  task automatic test_reset_armed();
    load_set(12'o3210, 3'd3);
    reset = 1'b1;
    tick();
    bus.land_valid = 1'b1;
    bus.land_pos   = 2'd3;
    tick();
    reset = 1'b0;
    bus.land_valid = 1'b0;
    checks++;
    if ({bus.colors_req, bus.plat_colors, bus.ball_color, bus.score, bus.lives, bus.hit,
         bus.miss, bus.game_over} !== '0) begin
      failures++;
      $display("FAIL reset_armed: got req=%b plats=%o ball=%0d score=%0d lives=%0d hit=%b miss=%b",
               bus.colors_req, bus.plat_colors, bus.ball_color, bus.score, bus.lives,
               bus.hit, bus.miss);
    end
    tick();
    checks++;
    if ({bus.hit, bus.miss, bus.colors_req, bus.game_over} !== 4'b0) begin
      failures++;
      $display("FAIL after_reset_idle: got hit=%b miss=%b req=%b over=%b want 0",
               bus.hit, bus.miss, bus.colors_req, bus.game_over);
    end
  endtask

  // Apply one round of spec rules to the model for the inputs currently driven.
  task automatic model_step();
    bit in_set;
    int sel;
    m_hit  = 0;
    m_miss = 0;
    if (m_phase == "idle" || m_phase == "over") begin
      if (bus.start) begin
        m_phase = "fetch";
        m_score = 0;
        m_lives = 3;
      end
    end else if (m_phase == "fetch") begin
      if (bus.colors_valid) begin
        in_set = 0;
        for (int k = 0; k < 4; k++)
          if (((bus.new_color_plats >> (3 * k)) & 12'h7) == 12'(bus.new_color_ball)) in_set = 1;
        if (in_set) begin
          m_plats = bus.new_color_plats;
          m_ball  = int'(bus.new_color_ball);
          m_phase = "armed";
        end
      end
    end else if (bus.land_valid) begin
      sel = int'((m_plats >> (3 * int'(bus.land_pos))) & 12'h7);
      if (sel == m_ball) begin
        m_hit   = 1;
        m_score = (m_score < 255) ? m_score + 1 : 255;
        m_phase = "fetch";
      end else begin
        m_miss  = 1;
        m_lives = m_lives - 1;
        m_phase = (m_lives == 0) ? "over" : "fetch";
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] plats;
    m_phase = "idle";
    m_plats = '0;
    m_ball  = 0;
    m_score = 0;
    m_lives = 0;
    for (int c = 0; c < 3000; c++) begin
      plats               = 12'($urandom);
      bus.start           = ($urandom_range(0, 7) == 0);
      bus.colors_valid    = $urandom_range(0, 1);
      bus.new_color_plats = plats;
      bus.new_color_ball  = ($urandom_range(0, 3) != 0) ?
                            3'(plats >> (3 * $urandom_range(0, 3))) : 3'($urandom);
      bus.land_valid      = ($urandom_range(0, 2) == 0);
      bus.land_pos        = 2'($urandom);
      model_step();
      tick();
      checks++;
      if ({bus.hit, bus.miss, bus.score, bus.lives} !==
          {m_hit, m_miss, 8'(m_score), 2'(m_lives)}) begin
        failures++;
        $display("FAIL rand_result cyc %0d: got hit=%b miss=%b score=%0d lives=%0d want %b %b %0d %0d",
                 c, bus.hit, bus.miss, bus.score, bus.lives, m_hit, m_miss, m_score, m_lives);
      end
      checks++;
      if ({bus.colors_req, bus.game_over, bus.plat_colors, bus.ball_color} !==
          {(m_phase == "fetch"), (m_phase == "over"), m_plats, 3'(m_ball)}) begin
        failures++;
        $display("FAIL rand_state cyc %0d: got req=%b over=%b plats=%o ball=%0d want phase %s plats=%o ball=%0d",
                 c, bus.colors_req, bus.game_over, bus.plat_colors, bus.ball_color,
                 m_phase, m_plats, m_ball);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_start();
    test_fetch_hit();
    test_miss_to_over();
    test_reject();
    test_ignored();
    test_saturate();
    test_reset_armed();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
